// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debug pager: segment width and the hex digit to
// seven-segment lookup. Segment encoding is active-high, bit order gfedcba
// (bit 6 = g, bit 0 = a); callers invert for active-low drive.
package debug_pkg;

  localparam int SEG_W = 7;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h67;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Conditions a raw, bouncing, active-low push-button into a single-cycle
// press pulse: 2-flop synchronizer, consecutive-cycle debouncer, and a
// falling-edge detector on the debounced level.
//
// Ports:
//   clk    in   clock, all state on the rising edge
//   rst    in   asynchronous reset, active-low
//   key_n  in   raw button, active-low, asynchronous to clk
//   pulse  out  one-cycle pulse per accepted press (stable 1->0)
module key_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  if (CYCLES < 1) begin : g_cfg_err
    $error("key_debounce: CYCLES must be at least 1");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    // Counter only runs while the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts the qualification window.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        // Only a high-to-low transition is a press; release is silent.
        pulse_d  = stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/debug_pager.sv
// debug_pager
// Pages a bank of 8-bit debug registers onto a multi-digit seven-segment
// display. Each page shows DIGITS/2 registers as hex. Pages advance on a
// debounced button press and/or on a periodic auto tick; a hold input
// freezes the captured register snapshot while still allowing paging.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous reset, active-low
//   regs_in     in   8*NUM_REGS, register i at [8i+7:8i]
//   step_n      in   raw push-button, active-low, may bounce
//   auto_en     in   enable timed page advance (level)
//   hold        in   freeze displayed snapshot (level)
//   seg_n       out  7*DIGITS active-low segments, digit d at [7d+6:7d], gfedcba
//   page        out  current page index
//   step_pulse  out  one-cycle pulse per accepted press
module debug_pager
  import debug_pkg::*;
#(
  parameter int  NUM_REGS        = 8,
  parameter int  DIGITS          = 4,
  parameter int  DEBOUNCE_CYCLES = 250000,
  parameter int  AUTO_TICKS      = 25000000,
  localparam int PAGES           = (DIGITS > 0) ? (2 * NUM_REGS / DIGITS) : 1,
  localparam int RPP             = DIGITS / 2,
  localparam int PW              = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*NUM_REGS-1:0]     regs_in,
  input  logic                      step_n,
  input  logic                      auto_en,
  input  logic                      hold,
  output logic [SEG_W*DIGITS-1:0]   seg_n,
  output logic [PW-1:0]             page,
  output logic                      step_pulse
);

  localparam int ACW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [ACW-1:0] TICK_LAST = ACW'(AUTO_TICKS - 1);
  localparam logic [PW-1:0]  PAGE_LAST = PW'(PAGES - 1);
  // Every digit shows "0" out of reset.
  localparam logic [SEG_W*DIGITS-1:0] SEG_RST = {DIGITS{~hex_to_seg(4'h0)}};

  if (DIGITS < 2 || (DIGITS % 2) != 0 || NUM_REGS < 1 ||
      ((2 * NUM_REGS) % DIGITS) != 0) begin : g_cfg_err
    $error("debug_pager: DIGITS must be even and divide 2*NUM_REGS");
  end

  if (AUTO_TICKS < 1 || DEBOUNCE_CYCLES < 1) begin : g_cnt_err
    $error("debug_pager: AUTO_TICKS and DEBOUNCE_CYCLES must be at least 1");
  end

  logic [ACW-1:0]            auto_cnt_q, auto_cnt_d;
  logic [PW-1:0]             page_q, page_d;
  logic [8*NUM_REGS-1:0]     snap_q, snap_d;
  logic [SEG_W*DIGITS-1:0]   seg_n_q, seg_n_d;
  logic                      auto_tick;
  logic                      advance;

  key_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (step_n),
    .pulse (step_pulse)
  );

  // Page word: first register of the page lands in the most significant
  // byte, so the display reads left-to-right in register order.
  function automatic logic [SEG_W*DIGITS-1:0] render(
    input logic [8*NUM_REGS-1:0] snap,
    input logic [PW-1:0]         pg
  );
    logic [4*DIGITS-1:0]     word;
    logic [SEG_W*DIGITS-1:0] segs;
    word = '0;
    for (int k = 0; k < RPP; k++) begin
      word[8*(RPP-1-k) +: 8] = snap[8*(int'(pg)*RPP + k) +: 8];
    end
    for (int d = 0; d < DIGITS; d++) begin
      segs[SEG_W*d +: SEG_W] = ~hex_to_seg(word[4*d +: 4]);
    end
    return segs;
  endfunction

  always_comb begin
    auto_tick = auto_en && (auto_cnt_q == TICK_LAST);

    // A press restarts the auto interval so the next timed advance comes a
    // full period after the manual one.
    if (!auto_en || step_pulse || auto_tick) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + ACW'(1);
    end

    // OR rather than sum: a press landing on a tick moves one page only.
    advance = step_pulse || auto_tick;
    page_d  = page_q;
    if (advance) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
    end

    snap_d  = hold ? snap_q : regs_in;

    // Rendered from the registered snapshot and page, giving two cycles of
    // latency from regs_in and one from a page change.
    seg_n_d = render(snap_q, page_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt_q <= '0;
      page_q     <= '0;
      snap_q     <= '0;
      seg_n_q    <= SEG_RST;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      page_q     <= page_d;
      snap_q     <= snap_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign page  = page_q;

endmodule

// File: tb/tb_debug_pager.sv
module tb_debug_pager;

  localparam int NR    = 8;
  localparam int DG    = 4;
  localparam int DB    = 4;
  localparam int AT    = 10;
  localparam int PAGES = 2 * NR / DG;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [27:0] RST_SEG  = 28'h8102040;
  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};

  logic            clk = 1'b0;
  logic            rst;
  logic [8*NR-1:0] regs_in;
  logic            step_n;
  logic            auto_en;
  logic            hold;
  logic [7*DG-1:0] seg_n;
  logic [1:0]      page;
  logic            step_pulse;

  int checks = 0;
  int errors = 0;
  logic [7:0] rm [NR];
  int pg_m;

  debug_pager #(
    .NUM_REGS        (NR),
    .DIGITS          (DG),
    .DEBOUNCE_CYCLES (DB),
    .AUTO_TICKS      (AT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regs_in    (regs_in),
    .step_n     (step_n),
    .auto_en    (auto_en),
    .hold       (hold),
    .seg_n      (seg_n),
    .page       (page),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected display: page pg shows reg 2pg (high byte) and reg 2pg+1 as a
  // 16-bit hex number, digit d showing nibble d.
  function automatic logic [7*DG-1:0] exp_seg(input logic [7:0] r [NR], input int pg);
    int word;
    logic [7*DG-1:0] res;
    word = int'(r[pg*2]) * 256 + int'(r[pg*2+1]);
    for (int d = 0; d < DG; d++) res[7*d +: 7] = ~SEG_TAB[(word >> (4*d)) & 15];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_regs();
    for (int i = 0; i < NR; i++) regs_in[8*i +: 8] = rm[i];
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NR; i++) rm[i] = 8'($urandom);
    drive_regs();
  endtask

  task automatic press(input int len, input int gap, output int pulses);
    pulses = 0;
    step_n = 1'b0;
    repeat (len) begin
      tick();
      if (step_pulse) pulses++;
    end
    step_n = 1'b1;
    repeat (gap) begin
      tick();
      if (step_pulse) pulses++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b0; step_n = 1'b1; auto_en = 1'b0; hold = 1'b0;
    rand_regs();
    repeat (3) tick();
    checks++;
    if (seg_n !== RST_SEG) begin errors++; $display("FAIL reset_seg: got %h expected %h", seg_n, RST_SEG); end
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL reset_page: got %0d expected 0", page); end
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", step_pulse); end
    rst = 1'b1;
    pg_m = 0;
    repeat (3) tick();
    press(8, 12, pulses);
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL reset_press_pulses: got %0d expected 1", pulses); end
    checks++;
    if (page !== 2'd1) begin errors++; $display("FAIL reset_press_page: got %0d expected 1", page); end
    // asynchronous assertion between clock edges
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (seg_n !== RST_SEG) begin errors++; $display("FAIL midrun_reset_seg: got %h expected %h", seg_n, RST_SEG); end
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL midrun_reset_page: got %0d expected 0", page); end
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL midrun_reset_pulse: got %b expected 0", step_pulse); end
    // snapshot must come out of reset cleared; hold keeps it that way
    hold = 1'b1;
    rand_regs();
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (seg_n !== RST_SEG) begin errors++; $display("FAIL reset_snapshot: got %h expected %h", seg_n, RST_SEG); end
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL reset_release_page: got %0d expected 0", page); end
    hold = 1'b0;
    pg_m = 0;
    repeat (2) tick();
    checks++;
    if (seg_n !== exp_seg(rm, 0)) begin errors++; $display("FAIL reset_unhold_seg: got %h expected %h", seg_n, exp_seg(rm, 0)); end
  endtask

  task automatic test_decode();
    logic [7:0] old [NR];
    old = rm;
    for (int i = 0; i < NR; i++) rm[i] = 8'h00;
    rm[0] = 8'h12;
    rm[1] = 8'h34;
    drive_regs();
    tick();
    checks++;
    if (seg_n !== exp_seg(old, pg_m)) begin errors++; $display("FAIL decode_1234_early: got %h expected %h", seg_n, exp_seg(old, pg_m)); end
    tick();
    checks++;
    if (seg_n !== SEG_1234) begin errors++; $display("FAIL decode_1234: got %h expected %h", seg_n, SEG_1234); end
    for (int n = 0; n < 8; n++) begin
      old = rm;
      rand_regs();
      tick();
      checks++;
      if (seg_n !== exp_seg(old, pg_m)) begin errors++; $display("FAIL decode_rand_early %0d: got %h expected %h", n, seg_n, exp_seg(old, pg_m)); end
      tick();
      checks++;
      if (seg_n !== exp_seg(rm, pg_m)) begin errors++; $display("FAIL decode_rand %0d: got %h expected %h", n, seg_n, exp_seg(rm, pg_m)); end
    end
  endtask

  task automatic test_debounce();
    int lens [10] = '{3, 8, 4, 1, 5, 2, 0, 0, 0, 0};
    int pulses;
    int expp;
    for (int i = 6; i < 10; i++) lens[i] = int'($urandom_range(1, 9));
    for (int i = 0; i < 10; i++) begin
      press(lens[i], 12, pulses);
      expp = (lens[i] >= DB) ? 1 : 0;
      pg_m = (pg_m + expp) % PAGES;
      checks++;
      if (pulses != expp) begin errors++; $display("FAIL debounce_pulses len=%0d: got %0d expected %0d", lens[i], pulses, expp); end
      checks++;
      if (int'(page) != pg_m) begin errors++; $display("FAIL debounce_page len=%0d: got %0d expected %0d", lens[i], page, pg_m); end
      checks++;
      if (seg_n !== exp_seg(rm, pg_m)) begin errors++; $display("FAIL debounce_seg len=%0d: got %h expected %h", lens[i], seg_n, exp_seg(rm, pg_m)); end
    end
  endtask

  // Press starts right after an edge: 2 sync + DB qualify edges, pulse
  // visible after edge 2+DB, page moves on the next edge, display one later.
  task automatic test_pages();
    int cur;
    int nxt;
    int ep;
    rand_regs();
    rm[2] = 8'hAB;
    rm[3] = 8'hCD;
    drive_regs();
    repeat (2) tick();
    for (int p = 0; p < 4; p++) begin
      cur = pg_m;
      nxt = (pg_m + 1) % PAGES;
      step_n = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        if (n == 9) step_n = 1'b1;
        tick();
        ep = (n >= DB + 3) ? nxt : cur;
        checks++;
        if (step_pulse !== (n == DB + 2)) begin errors++; $display("FAIL pages_pulse cyc=%0d: got %b expected %b", n, step_pulse, (n == DB + 2)); end
        checks++;
        if (int'(page) != ep) begin errors++; $display("FAIL pages_page cyc=%0d: got %0d expected %0d", n, page, ep); end
        checks++;
        if (seg_n !== exp_seg(rm, (n >= DB + 4) ? nxt : cur)) begin
          errors++; $display("FAIL pages_seg cyc=%0d: got %h expected %h", n, seg_n, exp_seg(rm, (n >= DB + 4) ? nxt : cur));
        end
      end
      pg_m = nxt;
      if (pg_m == 1) begin
        checks++;
        if (seg_n !== SEG_ABCD) begin errors++; $display("FAIL pages_abcd: got %h expected %h", seg_n, SEG_ABCD); end
      end
    end
  endtask

  // Timeline model: timed advances every AT edges after enable; a press
  // advances at edge s+DB+3 and restarts the interval from there.
  task automatic auto_scenario(input int s);
    int next_tick;
    int p_edge;
    int exp_pg;
    bit ev;
    auto_en = 1'b0;
    repeat (2) tick();
    auto_en = 1'b1;
    p_edge = s + DB + 3;
    next_tick = AT;
    exp_pg = pg_m;
    for (int n = 1; n <= 45; n++) begin
      if (n - 1 == s) step_n = 1'b0;
      if (n - 1 == s + 6) step_n = 1'b1;
      tick();
      ev = (n == next_tick) || (n == p_edge);
      if (ev) exp_pg = (exp_pg + 1) % PAGES;
      if (n == p_edge) next_tick = n + AT;
      else if (n == next_tick) next_tick = next_tick + AT;
      checks++;
      if (int'(page) != exp_pg) begin errors++; $display("FAIL auto_page s=%0d cyc=%0d: got %0d expected %0d", s, n, page, exp_pg); end
    end
    auto_en = 1'b0;
    pg_m = exp_pg;
    repeat (12) tick();
    checks++;
    if (int'(page) != pg_m) begin errors++; $display("FAIL auto_idle s=%0d: got %0d expected %0d", s, page, pg_m); end
  endtask

  task automatic test_auto();
    auto_scenario(13);
    auto_scenario(9);
    auto_scenario(int'($urandom_range(0, 30)));
  endtask

  task automatic test_hold();
    logic [7:0] frozen [NR];
    int pulses;
    frozen = rm;
    hold = 1'b1;
    rand_regs();
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (seg_n !== exp_seg(frozen, pg_m)) begin errors++; $display("FAIL hold_frozen %0d: got %h expected %h", n, seg_n, exp_seg(frozen, pg_m)); end
    end
    press(8, 12, pulses);
    pg_m = (pg_m + 1) % PAGES;
    checks++;
    if (int'(page) != pg_m) begin errors++; $display("FAIL hold_page: got %0d expected %0d", page, pg_m); end
    checks++;
    if (seg_n !== exp_seg(frozen, pg_m)) begin errors++; $display("FAIL hold_newpage: got %h expected %h", seg_n, exp_seg(frozen, pg_m)); end
    hold = 1'b0;
    tick();
    checks++;
    if (seg_n !== exp_seg(frozen, pg_m)) begin errors++; $display("FAIL unhold_early: got %h expected %h", seg_n, exp_seg(frozen, pg_m)); end
    tick();
    checks++;
    if (seg_n !== exp_seg(rm, pg_m)) begin errors++; $display("FAIL unhold_seg: got %h expected %h", seg_n, exp_seg(rm, pg_m)); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_debounce();
    test_pages();
    test_auto();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
